if_fetch_stage: RTL

- Instruction-fetch stage for the 32-bit RISC-V pipeline; sits directly upstream of the IF/ID pipeline register.
- Holds the PC and issues one-outstanding-request fetches to instruction memory over a req/gnt/rvalid handshake.
- Presents {if_pc, if_instr, if_valid} registered, so the plain 32-bit IF/ID register can capture it every clock.
- Handles decode stall (one-entry skid buffer) and EX-stage redirect (branch/jump flush); bubbles are output as NOP.

---
 rtl/if_fetch_stage_if.sv | 11 +
 rtl/if_fetch_stage.sv | 126 ++++++++++++
 2 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus: one outstanding req/gnt fetch, rvalid/rdata return.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// RISC-V instruction fetch: one-outstanding imem fetch, registered {if_pc, if_instr, if_valid}.
// Latency: instruction on if_* one cycle after rvalid; decode stall absorbed by a one-entry skid.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            if_pc,
    output logic [31:0]            if_instr,
    output logic                   if_valid
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic [31:0] if_pc_nxt, if_instr_nxt;
    logic        if_valid_nxt;
    logic [31:0] redir_target;
    logic        can_load;

    assign redir_target = {redirect_pc[31:2], 2'b00};
    assign can_load     = !if_valid || !stall;
    assign imem.req     = (state == S_REQ) && !rst;
    assign imem.addr    = pc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        req_pc_nxt     = req_pc;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;
        if_pc_nxt      = if_pc;
        if_instr_nxt   = if_instr;
        if_valid_nxt   = if_valid;

        // Nothing new loaded: bubble if decode drains, otherwise freeze.
        if (!stall) begin
            if_valid_nxt = 1'b0;
            if_instr_nxt = NOP_INSTR;
        end

        case (state)
            S_REQ: begin
                if (redirect) begin
                    pc_nxt = redir_target;
                    if (imem.gnt) state_nxt = S_DRAIN;
                end else if (imem.gnt) begin
                    req_pc_nxt = pc;
                    pc_nxt     = pc + 32'd4;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    state_nxt = S_REQ;
                    if (redirect) begin
                        pc_nxt = redir_target;
                    end else if (can_load) begin
                        if_pc_nxt    = req_pc;
                        if_instr_nxt = imem.rdata;
                        if_valid_nxt = 1'b1;
                    end else begin
                        skid_pc_nxt    = req_pc;
                        skid_instr_nxt = imem.rdata;
                        state_nxt      = S_HOLD;
                    end
                end else if (redirect) begin
                    pc_nxt    = redir_target;
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redirect)    pc_nxt    = redir_target;
                if (imem.rvalid) state_nxt = S_REQ;
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nxt    = redir_target;
                    state_nxt = S_REQ;
                end else if (!stall) begin
                    if_pc_nxt    = skid_pc;
                    if_instr_nxt = skid_instr;
                    if_valid_nxt = 1'b1;
                    state_nxt    = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase

        // A flush beats both stall and any load above.
        if (redirect) begin
            if_valid_nxt = 1'b0;
            if_instr_nxt = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            req_pc     <= 32'd0;
            skid_pc    <= 32'd0;
            skid_instr <= NOP_INSTR;
            if_pc      <= 32'd0;
            if_instr   <= NOP_INSTR;
            if_valid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            req_pc     <= req_pc_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_instr <= skid_instr_nxt;
            if_pc      <= if_pc_nxt;
            if_instr   <= if_instr_nxt;
            if_valid   <= if_valid_nxt;
        end
    end
endmodule
